dmem_responder: RTL and testbench



---
 rtl/riscv_pkg.sv | 21 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory responder: FSM states, the latched request,
// and the word geometry.
package riscv_pkg;

    localparam int DMEM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write mask and a registered read port.
// Contents are deliberately not reset.
module dmem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DMEM_WORD_BYTES-1:0] be,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, performs the
// masked write or word read, then holds the response until the core takes it.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// WAIT   | programmable wait states, counter runs down to 0
// ACCESS | one cycle: RAM access and error evaluation
// RESP   | rsp_valid high until rsp_ready is seen
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW         = $clog2(DEPTH_WORDS);
    localparam int BYTE_SHIFT = $clog2(DMEM_WORD_BYTES);
    localparam int CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_check
        $error("dmem_responder: DEPTH_WORDS must be a power of 2");
    end

    if (64'(BASE_ADDR) + 64'(DEPTH_WORDS) * 64'(DMEM_WORD_BYTES) > 64'h1_0000_0000) begin : g_wrap_check
        $error("dmem_responder: BASE_ADDR + DEPTH_WORDS*4 wraps the 32-bit address space");
    end

    dmem_state_e    state_q, state_d;
    dmem_req_t      req_q;
    logic [CW-1:0]  cnt_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic           rsp_err_q;
    logic           rd_ok_q;

    logic           accept;
    logic           cnt_dec;
    logic           ram_en;
    logic [31:0]    ram_rdata;
    logic [31:0]    offset;
    logic           in_range;
    logic           access_err;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets,
    // but the explicit lower-bound compare rejects them regardless.
    assign offset     = req_q.addr - BASE_ADDR;
    assign in_range   = (req_q.addr >= BASE_ADDR) && ((offset >> BYTE_SHIFT) < DEPTH_WORDS);
    assign access_err = (req_q.addr[BYTE_SHIFT-1:0] != '0) || !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt_q == '0) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        cnt_dec = 1'b0;
        ram_en  = 1'b0;
        unique case (state_q)
            IDLE:    accept  = req_valid && req_ready_q;
            WAIT:    cnt_dec = (cnt_q != '0);
            ACCESS:  ram_en  = !access_err;
            default: ;
        endcase
    end

    // req_ready is registered from the next state so it stays low during
    // reset and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            req_ready_q <= (state_d == IDLE);
            if (accept) begin
                req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                cnt_q <= CNT_LOAD;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == ACCESS) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= access_err;
                rd_ok_q     <= !req_q.we && !access_err;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (req_q.we),
        .addr  (offset[AW+BYTE_SHIFT-1:BYTE_SHIFT]),
        .be    (req_q.be),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    // RAM output only changes on a read in ACCESS, so it is stable through RESP.
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && rd_ok_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and one
// with three, sharing clock and request buses.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_a_n),
        .req_valid(req_valid_a), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_b_n),
        .req_valid(req_valid_b), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_req_ready : b_req_ready;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? a_rsp_valid : b_rsp_valid;
    endfunction

    function automatic logic [31:0] rdat(input int sel);
        return (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    endfunction

    function automatic logic rerr(input int sel);
        return (sel == 0) ? a_rsp_err : b_rsp_err;
    endfunction

    // One full transaction; request fields are scrambled right after the accept
    // edge, and the response is held for 'hold' cycles before being taken.
    task automatic tr(input string tag, input int sel, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                      input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat);
        int n;
        int lat;
        logic [31:0] cap;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        if (sel == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
        n = 0;
        while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
        chkb({tag, "_accept_in_time"}, (n < 20), 1'b1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = ~we; req_addr = 32'h0000_1010; req_wdata = ~wdata; req_be = ~be;
        lat = 1;
        while (!vld(sel) && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        cap = rdat(sel);
        chk({tag, "_rdata"}, cap, exp_rdata);
        chkb({tag, "_err"}, rerr(sel), exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chkb({tag, "_hold_valid"}, vld(sel), 1'b1);
            chk({tag, "_hold_rdata"}, rdat(sel), exp_rdata);
            chkb({tag, "_hold_req_ready"}, rdy(sel), 1'b0);
        end
        @(negedge clk);
        chkb({tag, "_no_overlap"}, rdy(sel), 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chkb({tag, "_pop_valid"}, vld(sel), 1'b0);
        chkb({tag, "_pop_req_ready"}, rdy(sel), 1'b1);
    endtask

    initial begin
        int n;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chkb("rst_req_ready", a_req_ready, 1'b0);
        chkb("rst_rsp_valid", a_rsp_valid, 1'b0);
        chk ("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chkb("rst_rsp_err",   a_rsp_err,   1'b0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        #1;
        chkb("rel_req_ready_before_edge", a_req_ready, 1'b0);
        @(posedge clk);
        #1;
        chkb("rel_req_ready_a", a_req_ready, 1'b1);
        chkb("rel_req_ready_b", b_req_ready, 1'b1);
        chkb("rel_rsp_valid_a", a_rsp_valid, 1'b0);

        // Round trip with one wait state.
        tr("st_1004", 0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0, 3);
        tr("ld_1004", 0, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0, 3);

        // Byte mask and empty mask.
        tr("st_1008",   0, 1'b1, 32'h0000_1008, 32'h1122_3344, 4'hF,    0, 32'h0,         1'b0, 3);
        tr("st_1008_m", 0, 1'b1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0101, 0, 32'h0,         1'b0, 3);
        tr("ld_1008_m", 0, 1'b0, 32'h0000_1008, 32'h0,         4'h0,    0, 32'h11BB_33DD, 1'b0, 3);
        tr("st_1008_z", 0, 1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0,         1'b0, 3);
        tr("ld_1008_z", 0, 1'b0, 32'h0000_1008, 32'h0,         4'hF,    0, 32'h11BB_33DD, 1'b0, 3);

        // Errors: misaligned, past the end, below base.
        tr("ld_1002",   0, 1'b0, 32'h0000_1002, 32'h0,         4'hF, 0, 32'h0,         1'b1, 3);
        tr("st_1000",   0, 1'b1, 32'h0000_1000, 32'h0102_0304, 4'hF, 0, 32'h0,         1'b0, 3);
        tr("st_1400",   0, 1'b1, 32'h0000_1400, 32'h9999_9999, 4'hF, 0, 32'h0,         1'b1, 3);
        tr("ld_1000",   0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 32'h0102_0304, 1'b0, 3);
        tr("ld_1400",   0, 1'b0, 32'h0000_1400, 32'h0,         4'h0, 0, 32'h0,         1'b1, 3);
        tr("ld_0ffc",   0, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 32'h0,         1'b1, 3);
        tr("st_13fc",   0, 1'b1, 32'h0000_13FC, 32'h5A5A_5A5A, 4'hF, 0, 32'h0,         1'b0, 3);
        tr("ld_13fc",   0, 1'b0, 32'h0000_13FC, 32'h0,         4'h0, 0, 32'h5A5A_5A5A, 1'b0, 3);

        // Backpressure: response held for five cycles.
        tr("ld_bp",     0, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 5, 32'hDEAD_BEEF, 1'b0, 3);

        // Three wait states: prime 0x100C, then reset during WAIT of a new store.
        tr("b_st_100c", 1, 1'b1, 32'h0000_100C, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 5);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0000_100C; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        req_valid_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        chkb("b_wait_req_ready", b_req_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_b_n = 1'b0;
        #1;
        chkb("b_rst_wait_rsp_valid", b_rsp_valid, 1'b0);
        chkb("b_rst_wait_req_ready", b_req_ready, 1'b0);
        chk ("b_rst_wait_rdata",     b_rsp_rdata, 32'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_b_n = 1'b1;
        tr("b_ld_100c", 1, 1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 5);

        // Asynchronous reset while a response is pending.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h0000_100C; req_be = 4'h0;
        req_valid_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chkb("b_resp_pending_valid", b_rsp_valid, 1'b1);
        chk ("b_resp_pending_rdata", b_rsp_rdata, 32'h1234_5678);
        @(negedge clk);
        #2;
        rst_b_n = 1'b0;
        #1;
        chkb("b_rst_resp_valid", b_rsp_valid, 1'b0);
        chk ("b_rst_resp_rdata", b_rsp_rdata, 32'h0);
        @(negedge clk);
        rst_b_n = 1'b1;
        @(posedge clk);
        #1;
        chkb("b_rerel_req_ready", b_req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
